store_merge_unit: RTL and testbench



---
 rtl/store_merge_unit.sv | 129 ++++++++++++
 tb/tb_store_merge_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_merge_unit.sv
// Store path: word stores write straight through, sub-word stores
// read the containing word, merge the new lanes in and write it back.
module store_merge_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_size,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        misaligned
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] merge_q, merge_d;
  logic [1:0]  size_q, size_d;
  logic        aligned;
  logic [31:0] merged;

  always_comb begin
    aligned = 1'b0;
    unique case (store_size)
      SZ_WORD: aligned = (addr[1:0] == 2'b00);
      SZ_HALF: aligned = ~addr[0];
      SZ_BYTE: aligned = 1'b1;
      default: aligned = 1'b0;
    endcase
  end

  // Little-endian lane replacement over the word just read back.
  always_comb begin
    merged = mem_rdata;
    if (size_q == SZ_BYTE) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
    end else if (size_q == SZ_HALF) begin
      if (addr_q[1]) merged[31:16] = data_q[15:0];
      else           merged[15:0]  = data_q[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    merge_d = merge_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = addr;
          data_d = store_data;
          size_d = store_size;
          if (!aligned)                 state_d = S_ERR;
          else if (store_size == SZ_WORD) state_d = S_WRITE;
          else                          state_d = S_READ;
        end
      end
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: begin
        merge_d = merged;
        state_d = S_WRITE;
      end
      S_WRITE:   state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      merge_q <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      merge_q <= merge_d;
      size_q  <= size_d;
    end
  end

  always_comb begin
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wr     = 1'b0;
    busy       = (state_q != S_IDLE);
    done       = 1'b0;
    misaligned = 1'b0;
    unique case (state_q)
      S_READ, S_CAPTURE: mem_addr = {addr_q[31:2], 2'b00};
      S_WRITE: begin
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wr    = 1'b1;
        mem_wdata = (size_q == SZ_WORD) ? data_q : merge_q;
      end
      S_DONE: done = 1'b1;
      S_ERR: begin
        done       = 1'b1;
        misaligned = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: per-cycle output trace from a
// request-level model, plus literal checks of committed memory words.
module tb_store_merge_unit;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic        busy;
    logic        done;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  store_size = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        busy;
  logic        done;
  logic        misaligned;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  logic [31:0] ram [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  exp_t        expq [int];

  store_merge_unit dut (
    .clk(clk), .reset(reset), .start(start),
    .store_size(store_size), .addr(addr),
    .store_data(store_data), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wr(mem_wr), .busy(busy), .done(done),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data one cycle after address, write on edge.
  initial mem_rdata = '0;
  always @(posedge clk) begin
    cyc = cyc + 1;
    mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : 32'h0;
    if (mem_wr) ram[mem_addr] = mem_wdata;
  end

  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    if (chk_en) begin
      e = expq.exists(cyc) ? expq[cyc] : '0;
      g = '{mem_addr, mem_wdata, mem_wr, busy, done, misaligned};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL cyc%0d outputs got a=%h wd=%h wr=%b bz=%b dn=%b mis=%b exp a=%h wd=%h wr=%b bz=%b dn=%b mis=%b",
          cyc, g.addr, g.wdata, g.wr, g.busy, g.done, g.mis,
          e.addr, e.wdata, e.wr, e.busy, e.done, e.mis);
      end
    end
  end

  function automatic logic [31:0] model_merge(
    input logic [31:0] old, input logic [31:0] a,
    input logic [1:0] sz, input logic [31:0] d);
    logic [7:0] b [4];
    int n;
    logic [31:0] r;
    n = (sz == 2'b10) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    for (int j = 0; j < n; j++) b[int'(a[1:0]) + j] = d[8*j +: 8];
    for (int i = 0; i < 4; i++) r[8*i +: 8] = b[i];
    return r;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    ram[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic chk_mem(input string nm, input logic [31:0] a,
                         input logic [31:0] want);
    logic [31:0] got;
    got = ram.exists(a) ? ram[a] : 32'h0;
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s mem[%h] got %h exp %h", nm, a, got, want);
    end
  endtask

  // rst_at = n asserts reset in cycle n of the request (0 = never);
  // busyp re-pulses start with a word store in cycles 1..3.
  task automatic issue(input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input int rst_at,
                       input bit busyp);
    int c;
    int len;
    int wcyc;
    bit ok;
    logic [31:0] wa;
    logic [31:0] nv;
    exp_t e [int];
    c  = cyc;
    wa = {a[31:2], 2'b00};
    ok = (sz == 2'b00) ? (a[1:0] == 2'b00) :
         (sz == 2'b01) ? !a[0] : (sz == 2'b10);
    if (!ok) begin
      len = 1; wcyc = 0;
      e[1] = '{32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1};
    end else if (sz == 2'b00) begin
      len = 2; wcyc = 1; nv = d;
      e[1] = '{wa, d, 1'b1, 1'b1, 1'b0, 1'b0};
      e[2] = '{32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    end else begin
      len = 4; wcyc = 3;
      nv = model_merge(ref_mem.exists(wa) ? ref_mem[wa] : 32'h0, a, sz, d);
      e[1] = '{wa, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
      e[2] = '{wa, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
      e[3] = '{wa, nv, 1'b1, 1'b1, 1'b0, 1'b0};
      e[4] = '{32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    end
    for (int n = 1; n <= len; n++)
      if (rst_at == 0 || n <= rst_at) expq[c + n] = e[n];
    if (wcyc != 0 && (rst_at == 0 || wcyc <= rst_at)) ref_mem[wa] = nv;
    start = 1'b1; store_size = sz; addr = a; store_data = d;
    for (int n = 1; n <= len; n++) begin
      @(posedge clk); #1;
      start = busyp && n <= 3;
      if (busyp) begin
        store_size = 2'b00; addr = 32'h200; store_data = 32'hCAFEF00D;
      end
      reset = (n == rst_at);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    @(posedge clk); #1;
    chk_en = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(1);

    preload(32'h104, 32'h0);
    preload(32'h100, 32'hAABBCCDD);
    issue(2'b00, 32'h104, 32'hDEADBEEF, 0, 0);
    chk_mem("sw", 32'h104, 32'hDEADBEEF);

    issue(2'b10, 32'h103, 32'h12345677, 0, 0);
    chk_mem("sb3", 32'h100, 32'h77BBCCDD);
    preload(32'h100, 32'hAABBCCDD);
    issue(2'b10, 32'h100, 32'h12345677, 0, 0);
    chk_mem("sb0", 32'h100, 32'hAABBCC77);
    preload(32'h100, 32'hAABBCCDD);
    issue(2'b10, 32'h101, 32'h12345677, 0, 0);
    chk_mem("sb1", 32'h100, 32'hAABB77DD);
    preload(32'h100, 32'hAABBCCDD);
    issue(2'b10, 32'h102, 32'h12345677, 0, 0);
    chk_mem("sb2", 32'h100, 32'hAA77CCDD);

    preload(32'h100, 32'hAABBCCDD);
    issue(2'b01, 32'h102, 32'h0000BEEF, 0, 0);
    chk_mem("sh2", 32'h100, 32'hBEEFCCDD);
    preload(32'h100, 32'hAABBCCDD);
    issue(2'b01, 32'h100, 32'h0000BEEF, 0, 0);
    chk_mem("sh0", 32'h100, 32'hAABBBEEF);

    issue(2'b01, 32'h101, 32'h11111111, 0, 0);
    issue(2'b00, 32'h102, 32'h22222222, 0, 0);
    issue(2'b11, 32'h100, 32'h33333333, 0, 0);
    chk_mem("err", 32'h100, 32'hAABBBEEF);

    issue(2'b00, 32'h108, 32'h11111111, 0, 0);
    issue(2'b00, 32'h10C, 32'h22222222, 0, 0);
    chk_mem("b2b0", 32'h108, 32'h11111111);
    chk_mem("b2b1", 32'h10C, 32'h22222222);

    preload(32'h100, 32'hAABBCCDD);
    preload(32'h200, 32'h55555555);
    issue(2'b10, 32'h103, 32'h12345677, 0, 1);
    chk_mem("busy_sb", 32'h100, 32'h77BBCCDD);
    chk_mem("busy_nosw", 32'h200, 32'h55555555);
    issue(2'b00, 32'h200, 32'hCAFEF00D, 0, 0);
    chk_mem("busy_sw", 32'h200, 32'hCAFEF00D);

    preload(32'h100, 32'hAABBCCDD);
    issue(2'b10, 32'h103, 32'h12345677, 2, 0);
    idle(2);
    chk_mem("rst_cap", 32'h100, 32'hAABBCCDD);
    preload(32'h300, 32'h0);
    issue(2'b00, 32'h300, 32'hA5A5A5A5, 1, 0);
    idle(2);
    chk_mem("rst_wr", 32'h300, 32'hA5A5A5A5);

    preload(32'h400, 32'h0);
    reset = 1'b1; start = 1'b1;
    store_size = 2'b00; addr = 32'h400; store_data = 32'h99999999;
    idle(1);
    reset = 1'b0; start = 1'b0;
    idle(4);
    chk_mem("rst_start", 32'h400, 32'h0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
